// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, bus layouts and the
// except_zip bit that flags an exception.
package mem_stage_pkg;

    localparam int ES2MS_BUS_W  = 119;
    localparam int ES_RF_ZIP_W  = 40;
    localparam int MS2WS_BUS_W  = 152;
    localparam int EXCEPT_ZIP_W = 82;
    localparam int EX_BIT       = 2;
    localparam int LD_ZIP_W     = 5;

    typedef struct packed {
        logic ld_b;
        logic ld_bu;
        logic ld_h;
        logic ld_hu;
        logic ld_w;
    } ld_zip_t;

    typedef struct packed {
        ld_zip_t                  ld_zip;
        logic [31:0]              pc;
        logic [EXCEPT_ZIP_W-1:0]  except_zip;
    } es2ms_bus_t;

    // Same layout for the EXE input zip and the MEM forwarding zip; the low
    // word is alu_result on the way in and rf_wdata on the way out.
    typedef struct packed {
        logic        csr_re;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] data;
    } rf_zip_t;

    typedef struct packed {
        logic                     rf_we;
        logic [4:0]               rf_waddr;
        logic [31:0]              rf_wdata;
        logic [31:0]              pc;
        logic [EXCEPT_ZIP_W-1:0]  except_zip;
    } ms2ws_bus_t;

    function automatic logic has_ex(input logic [EXCEPT_ZIP_W-1:0] except_zip);
        return except_zip[EX_BIT];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline signals around the MEM stage. slave is the MEM stage view, master
// is the view of the surrounding EXE/WB/SRAM logic.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                    es2ms_valid;
    logic [ES2MS_BUS_W-1:0]  es2ms_bus;
    logic [ES_RF_ZIP_W-1:0]  es_rf_zip;
    logic [31:0]             data_sram_rdata;
    logic                    ws_allowin;
    logic                    wb_ex;
    logic                    ms_allowin;
    logic                    ms2ws_valid;
    logic [MS2WS_BUS_W-1:0]  ms2ws_bus;
    logic [ES_RF_ZIP_W-1:0]  ms_rf_zip;
    logic                    ms_ex;
    logic [31:0]             ms_pc;

    modport slave (
        input  es2ms_valid, es2ms_bus, es_rf_zip, data_sram_rdata, ws_allowin, wb_ex,
        output ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip, ms_ex, ms_pc
    );

    modport master (
        output es2ms_valid, es2ms_bus, es_rf_zip, data_sram_rdata, ws_allowin, wb_ex,
        input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip, ms_ex, ms_pc
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load alignment and extension: shifts the addressed byte/half down to bit 0
// and sign- or zero-extends it; word loads pass the raw word through.
module load_align
    import mem_stage_pkg::*;
(
    input  ld_zip_t     ld_zip,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = rdata;
        if (ld_zip.ld_b) begin
            result = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end else if (ld_zip.ld_bu) begin
            result = {24'd0, w_shifted[7:0]};
        end else if (ld_zip.ld_h) begin
            result = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end else if (ld_zip.ld_hu) begin
            result = {16'd0, w_shifted[15:0]};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction between EXE and WB, buffers the
// synchronous SRAM load data across stalls and builds the WB/forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  pipe
);

    logic        r_ms_valid;
    logic        r_first;
    logic [31:0] r_rdata_buf;
    es2ms_bus_t  r_es2ms;
    rf_zip_t     r_rf;

    logic        w_ms_allowin;
    logic        w_accept;
    logic [31:0] w_rdata;
    logic [31:0] w_load_result;
    logic [31:0] w_rf_wdata;
    logic        w_ex;
    ms2ws_bus_t  w_ms2ws;
    rf_zip_t     w_ms_rf;

    assign w_ms_allowin = ~r_ms_valid | pipe.ws_allowin;
    assign w_accept     = pipe.es2ms_valid & w_ms_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid  <= 1'b0;
            r_first     <= 1'b0;
            r_rdata_buf <= 32'd0;
            r_es2ms     <= '0;
            r_rf        <= '0;
        end else begin
            if (pipe.wb_ex) begin
                r_ms_valid <= 1'b0;
            end else if (w_ms_allowin) begin
                r_ms_valid <= pipe.es2ms_valid;
            end
            r_first <= w_accept;
            // SRAM data is only guaranteed in the first cycle; keep it for stalls.
            if (r_first) begin
                r_rdata_buf <= pipe.data_sram_rdata;
            end
            if (w_accept) begin
                r_es2ms <= pipe.es2ms_bus;
                r_rf    <= pipe.es_rf_zip;
            end
        end
    end

    assign w_rdata = r_first ? pipe.data_sram_rdata : r_rdata_buf;

    load_align u_load_align (
        .ld_zip (r_es2ms.ld_zip),
        .offset (r_rf.data[1:0]),
        .rdata  (w_rdata),
        .result (w_load_result)
    );

    assign w_rf_wdata = r_rf.res_from_mem ? w_load_result : r_rf.data;
    assign w_ex       = has_ex(r_es2ms.except_zip);

    always_comb begin
        w_ms2ws            = '0;
        w_ms2ws.rf_we      = r_rf.rf_we & ~w_ex;
        w_ms2ws.rf_waddr   = r_rf.rf_waddr;
        w_ms2ws.rf_wdata   = w_rf_wdata;
        w_ms2ws.pc         = r_es2ms.pc;
        w_ms2ws.except_zip = r_es2ms.except_zip;
    end

    always_comb begin
        w_ms_rf              = '0;
        w_ms_rf.csr_re       = r_rf.csr_re & r_ms_valid;
        w_ms_rf.res_from_mem = r_rf.res_from_mem & r_ms_valid;
        w_ms_rf.rf_we        = r_rf.rf_we & r_ms_valid;
        w_ms_rf.rf_waddr     = r_rf.rf_waddr;
        w_ms_rf.data         = w_rf_wdata;
    end

    assign pipe.ms_allowin  = w_ms_allowin;
    assign pipe.ms2ws_valid = r_ms_valid;
    assign pipe.ms2ws_bus   = w_ms2ws;
    assign pipe.ms_rf_zip   = w_ms_rf;
    assign pipe.ms_ex       = r_ms_valid & w_ex;
    assign pipe.ms_pc       = r_es2ms.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, stall buffering, flush,
// exception gating, back-to-back throughput and asynchronous reset.
module tb_mem_stage;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_stage_if u_if ();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_instr(input logic [4:0] ld, input logic [31:0] pc,
                               input logic [31:0] alu, input logic rfm,
                               input logic we, input logic [4:0] waddr,
                               input logic ex, input logic [31:0] rdata);
        logic [81:0] exzip;
        exzip = ex ? 82'd4 : 82'd0;
        u_if.es2ms_bus       = {ld, pc, exzip};
        u_if.es_rf_zip       = {1'b0, rfm, we, waddr, alu};
        u_if.data_sram_rdata = rdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        u_if.es2ms_valid = 1'b0;
        u_if.ws_allowin  = 1'b1;
        u_if.wb_ex       = 1'b0;
        drive_instr(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got=%b exp=0", u_if.ms2ws_valid);
        end
        n_cmp++;
        if (u_if.ms_ex !== 1'b0) begin
            n_err++; $display("FAIL reset_ms_ex got=%b exp=0", u_if.ms_ex);
        end
        n_cmp++;
        if (u_if.ms_pc !== 32'd0) begin
            n_err++; $display("FAIL reset_ms_pc got=%h exp=0", u_if.ms_pc);
        end
        n_cmp++;
        if (u_if.ms_rf_zip !== 40'd0) begin
            n_err++; $display("FAIL reset_rf_zip got=%h exp=0", u_if.ms_rf_zip);
        end
        n_cmp++;
        if (u_if.ms_allowin !== 1'b1) begin
            n_err++; $display("FAIL reset_allowin got=%b exp=1", u_if.ms_allowin);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_ext;
        logic [4:0]  ld_t   [5];
        logic [31:0] alu_t  [5];
        logic [31:0] rd_t   [5];
        logic [31:0] exp_t  [5];
        ld_t  = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        alu_t = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0002, 32'h1000_0000};
        rd_t  = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000};
        exp_t = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
        u_if.ws_allowin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_instr(ld_t[i], 32'h0000_1000 + i * 4, alu_t[i], 1'b1, 1'b1, 5'd5, 1'b0, rd_t[i]);
            u_if.es2ms_valid = 1'b1;
            @(posedge clk);
            #1 u_if.es2ms_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (u_if.ms2ws_valid !== 1'b1) begin
                n_err++; $display("FAIL load%0d_valid got=%b exp=1", i, u_if.ms2ws_valid);
            end
            n_cmp++;
            if (u_if.ms2ws_bus[145:114] !== exp_t[i]) begin
                n_err++; $display("FAIL load%0d_wdata got=%h exp=%h", i, u_if.ms2ws_bus[145:114], exp_t[i]);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_stall;
        @(negedge clk);
        drive_instr(5'b00001, 32'h0000_0100, 32'h2000_0000, 1'b1, 1'b1, 5'd7, 1'b0, 32'h1234_5678);
        u_if.es2ms_valid = 1'b1;
        u_if.ws_allowin  = 1'b0;
        @(posedge clk);
        #1 u_if.es2ms_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (u_if.ms2ws_bus[145:114] !== 32'h1234_5678 || u_if.ms_allowin !== 1'b0) begin
            n_err++; $display("FAIL stall_first got=%h/%b exp=12345678/0", u_if.ms2ws_bus[145:114], u_if.ms_allowin);
        end
        @(posedge clk);
        #1;
        drive_instr(5'b00001, 32'h0000_0200, 32'h3000_0000, 1'b0, 1'b1, 5'd8, 1'b0, 32'hDEAD_BEEF);
        u_if.es2ms_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (u_if.ms2ws_bus[145:114] !== 32'h1234_5678) begin
                n_err++; $display("FAIL stall%0d_wdata got=%h exp=12345678", i, u_if.ms2ws_bus[145:114]);
            end
            n_cmp++;
            if (u_if.ms_allowin !== 1'b0 || u_if.ms2ws_valid !== 1'b1) begin
                n_err++; $display("FAIL stall%0d_hs got=%b/%b exp=0/1", i, u_if.ms_allowin, u_if.ms2ws_valid);
            end
            n_cmp++;
            if (u_if.ms_pc !== 32'h0000_0100) begin
                n_err++; $display("FAIL stall%0d_pc got=%h exp=00000100", i, u_if.ms_pc);
            end
        end
        u_if.es2ms_valid = 1'b0;
        u_if.ws_allowin  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_drain got=%b exp=0", u_if.ms2ws_valid);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        drive_instr(5'd0, 32'h0000_0300, 32'h0000_0033, 1'b0, 1'b1, 5'd3, 1'b0, 32'd0);
        u_if.es2ms_valid = 1'b1;
        u_if.ws_allowin  = 1'b1;
        u_if.wb_ex       = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_pulse got=%b exp=0", u_if.ms2ws_valid);
        end
        u_if.es2ms_valid = 1'b0;
        u_if.wb_ex       = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_allowin !== 1'b1) begin
            n_err++; $display("FAIL flush_after got=%b/%b exp=0/1", u_if.ms2ws_valid, u_if.ms_allowin);
        end
        drive_instr(5'd0, 32'h0000_0304, 32'h0000_0034, 1'b0, 1'b1, 5'd3, 1'b0, 32'd0);
        u_if.es2ms_valid = 1'b1;
        u_if.ws_allowin  = 1'b0;
        @(posedge clk);
        #1 u_if.es2ms_valid = 1'b0;
        u_if.wb_ex = 1'b1;
        @(posedge clk);
        #1 u_if.wb_ex = 1'b0;
        u_if.ws_allowin = 1'b1;
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_held got=%b exp=0", u_if.ms2ws_valid);
        end
    endtask

    task automatic test_exception;
        @(negedge clk);
        drive_instr(5'd0, 32'h0000_0500, 32'h0000_0055, 1'b0, 1'b1, 5'd9, 1'b1, 32'd0);
        u_if.es2ms_valid = 1'b1;
        u_if.ws_allowin  = 1'b0;
        @(posedge clk);
        #1 u_if.es2ms_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (u_if.ms_ex !== 1'b1) begin
            n_err++; $display("FAIL ex_ms_ex got=%b exp=1", u_if.ms_ex);
        end
        n_cmp++;
        if (u_if.ms2ws_bus[151] !== 1'b0) begin
            n_err++; $display("FAIL ex_bus_we got=%b exp=0", u_if.ms2ws_bus[151]);
        end
        n_cmp++;
        if (u_if.ms_rf_zip !== {3'b001, 5'd9, 32'h0000_0055}) begin
            n_err++; $display("FAIL ex_rf_zip got=%h exp=%h", u_if.ms_rf_zip, {3'b001, 5'd9, 32'h0000_0055});
        end
        u_if.ws_allowin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (u_if.ms_ex !== 1'b0 || u_if.ms_rf_zip[39:37] !== 3'b000) begin
            n_err++; $display("FAIL ex_drain got=%b/%b exp=0/000", u_if.ms_ex, u_if.ms_rf_zip[39:37]);
        end
    endtask

    task automatic test_back_to_back;
        u_if.ws_allowin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_cmp++;
                if (u_if.ms2ws_valid !== 1'b1 || u_if.ms2ws_bus[145:114] !== 32'hA000_0000 + k - 1) begin
                    n_err++; $display("FAIL b2b%0d got=%b/%h exp=1/%h", k - 1, u_if.ms2ws_valid,
                                      u_if.ms2ws_bus[145:114], 32'hA000_0000 + k - 1);
                end
                n_cmp++;
                if (u_if.ms_pc !== 32'h0000_0400 + (k - 1) * 4) begin
                    n_err++; $display("FAIL b2b%0d_pc got=%h exp=%h", k - 1, u_if.ms_pc, 32'h0000_0400 + (k - 1) * 4);
                end
            end
            if (k < 4) begin
                drive_instr(5'd0, 32'h0000_0400 + k * 4, 32'hA000_0000 + k, 1'b0, 1'b1, 5'd1, 1'b0, 32'hFFFF_FFFF);
                u_if.es2ms_valid = 1'b1;
            end else begin
                u_if.es2ms_valid = 1'b0;
            end
        end
        @(posedge clk);
        // Second run: reset lands while the second instruction sits in MEM.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_instr(5'd0, 32'h0000_0600 + k * 4, 32'hB000_0000 + k, 1'b0, 1'b1, 5'd2, 1'b0, 32'd0);
            u_if.es2ms_valid = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b1 || u_if.ms_pc !== 32'h0000_0604) begin
            n_err++; $display("FAIL b2b_second got=%b/%h exp=1/00000604", u_if.ms2ws_valid, u_if.ms_pc);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_ex !== 1'b0 || u_if.ms_pc !== 32'd0 ||
            u_if.ms_rf_zip !== 40'd0 || u_if.ms2ws_bus !== 152'd0) begin
            n_err++; $display("FAIL async_reset got=%b/%b/%h/%h exp=0/0/0/0", u_if.ms2ws_valid,
                              u_if.ms_ex, u_if.ms_pc, u_if.ms_rf_zip);
        end
        u_if.es2ms_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        @(negedge clk);
        drive_instr(5'b00001, 32'h0000_0700, 32'h4000_0000, 1'b1, 1'b1, 5'd4, 1'b0, 32'h5555_AAAA);
        u_if.es2ms_valid = 1'b1;
        u_if.ws_allowin  = 1'b0;
        @(posedge clk);
        #1 u_if.es2ms_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b1) begin
            n_err++; $display("FAIL midstall_held got=%b exp=1", u_if.ms2ws_valid);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_pc !== 32'd0) begin
            n_err++; $display("FAIL midstall_reset got=%b/%h exp=0/0", u_if.ms2ws_valid, u_if.ms_pc);
        end
        @(negedge clk);
        reset = 1'b0;
        u_if.ws_allowin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (u_if.ms2ws_valid !== 1'b0) begin
                n_err++; $display("FAIL midstall_after%0d got=%b exp=0", i, u_if.ms2ws_valid);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_ext();
        test_stall();
        test_flush();
        test_exception();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge.
REQ-002 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have port es2ms_valid, input, 1 bit, meaning the EXE stage offers an instruction.
REQ-004 The block SHALL have port es2ms_bus, input, 119 bits, packed {ld_zip[4:0] = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, pc[31:0], except_zip[81:0]}.
REQ-005 The block SHALL have port es_rf_zip, input, 40 bits, packed {csr_re, res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}.
REQ-006 The block SHALL have port data_sram_rdata, input, 32 bits, the synchronous SRAM read data, valid exactly one cycle after EXE issued the access.
REQ-007 The block SHALL have port ws_allowin, input, 1 bit, meaning WB can accept.
REQ-008 The block SHALL have port wb_ex, input, 1 bit, the exception/ertn flush from WB.
REQ-009 The block SHALL have port ms_allowin, output, 1 bit, meaning MEM can accept.
REQ-010 The block SHALL have port ms2ws_valid, output, 1 bit, meaning the instruction is offered to WB.
REQ-011 The block SHALL have port ms2ws_bus, output, 152 bits, packed {rf_we, rf_waddr[4:0], rf_wdata[31:0], pc[31:0], except_zip[81:0]}.
REQ-012 The block SHALL have port ms_rf_zip, output, 40 bits, packed {csr_re, res_from_mem, rf_we, rf_waddr, rf_wdata}, the forwarding/hazard info for ID.
REQ-013 The block SHALL have port ms_ex, output, 1 bit, meaning the MEM instruction carries an exception.
REQ-014 The block SHALL have port ms_pc, output, 32 bits, the PC of the MEM instruction.

Function
REQ-015 ms_ready_go SHALL be constant 1; ms_allowin SHALL be ~ms_valid | ws_allowin; ms2ws_valid SHALL be ms_valid.
REQ-016 ms_valid SHALL be cleared when wb_ex=1, else it SHALL load es2ms_valid when ms_allowin=1; wb_ex has priority over acceptance in the same cycle.
REQ-017 Payload registers (es2ms_bus, es_rf_zip) SHALL load only when es2ms_valid & ms_allowin, and SHALL otherwise hold.
REQ-018 A first-cycle flag SHALL be set on every accept and cleared on the following cycle.
REQ-019 In the first cycle the block SHALL capture data_sram_rdata into rdata_buf; the effective read data SHALL be first ? data_sram_rdata : rdata_buf, so stalls of any length return the original load data.
REQ-020 Byte offset SHALL be alu_result[1:0]; the shifted word SHALL be rdata >> (8*offset).
REQ-021 ld_b SHALL sign-extend byte 0 of the shifted word; ld_bu SHALL zero-extend it; ld_h and ld_hu SHALL sign- and zero-extend half 0 respectively; ld_w SHALL pass the word unshifted.
REQ-022 rf_wdata SHALL be the load result when res_from_mem=1, else alu_result.
REQ-023 ms_ex SHALL be ms_valid & except_zip[2].
REQ-024 rf_we in ms2ws_bus SHALL be gated by ~except_zip[2].
REQ-025 ms_rf_zip's csr_re, res_from_mem and rf_we SHALL each be ANDed with ms_valid.
REQ-026 A back-to-back accept (ws_allowin=1 every cycle) SHALL give a throughput of 1 instr/cycle with no bubble.

Reset
REQ-027 On reset the block SHALL clear ms_valid, the first flag, rdata_buf and all payload registers to 0, giving ms2ws_valid=0, ms_ex=0, ms_pc=0 and ms_rf_zip=0.
REQ-028 A reset asserted mid-stall SHALL discard the held instruction with no output pulse.

Structure
REQ-029 Bus widths (119, 40, 152, 82) and the except_zip ex-bit index (2) SHALL live in a shared pipeline package used by all stages.
REQ-030 Load alignment/extension SHALL be one combinational sub-module, load_align, with inputs ld_zip, offset and rdata, and output result.

Verification
REQ-031 The bench SHALL drive ld_b at addr 0x...3 with rdata 0x80FF_1234 -> rf_wdata 0xFFFF_FF80; ld_bu at the same address SHALL give 0x0000_0080.
REQ-032 The bench SHALL drive ld_h at addr 0x...2 with rdata 0x8001_0000 -> 0xFFFF_8001; ld_w at addr 0x...0 SHALL give 0x8001_0000.
REQ-033 The bench SHALL drive a load with ws_allowin=0 for 3 cycles while rdata changes to 0xDEAD_BEEF after cycle 1 -> ms2ws_bus rf_wdata SHALL stay the original value and ms_allowin=0 throughout.
REQ-034 The bench SHALL drive wb_ex=1 in the same cycle as es2ms_valid=1 and ms_allowin=1 -> ms_valid=0 the next cycle and no ms2ws_valid pulse.
REQ-035 The bench SHALL drive an instruction with except_zip[2]=1 and rf_we=1 -> ms_ex=1 and bus rf_we=0.
REQ-036 The bench SHALL drive 4 back-to-back ALU instructions with ws_allowin=1 -> 4 consecutive ms2ws_valid cycles with rf_wdata = alu_result; reset asserted after the second SHALL make all outputs 0 asynchronously.
